// File: rtl/one_cold_scan_capture.sv
// Sequencer/capture for a shared 7:1 one-cold-select mux: steps the select code
// through all lanes, samples din after a settle window, and publishes a 7-bit frame.
// Optional GAP idle check (sticky err output) is enabled by defining SCAN_IDLE_CHECK_EN.
module one_cold_scan_capture #(
  parameter int SETTLE = 4,
  parameter int LANES  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic             din,
  output logic [LANES-1:0] select,
  output logic [LANES-1:0] data,
  output logic             done,
  output logic             busy
`ifdef SCAN_IDLE_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int DW = $clog2(SETTLE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE - 1);
  localparam logic [2:0]    LANE_LAST  = 3'(LANES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

  state_t           state, state_nxt;
  logic [2:0]       lane;
  logic [DW-1:0]    dwell;
  logic [LANES-1:0] shadow;
  logic             sample, last;

  // Lane k pulls select bit (LANES-1-k) low; all other lines stay high.
  function automatic logic [LANES-1:0] lane_code(input logic [2:0] k);
    return ~(LANES'(1) << (LANE_LAST - k));
  endfunction

  assign sample = (state == SCAN) && (dwell == DWELL_LAST);
  assign last   = sample && (lane == LANE_LAST);
  assign busy   = (state == SCAN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start | cont) state_nxt = SCAN;
      SCAN:    if (last) state_nxt = GAP;
      GAP:     state_nxt = (start | cont) ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      select <= '1;
      data   <= '0;
      done   <= 1'b0;
      lane   <= '0;
      dwell  <= '0;
      shadow <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        SCAN: begin
          if (sample) begin
            shadow[lane] <= din;
            dwell        <= '0;
            if (last) begin
              // Lane 6 goes straight into the frame word, bypassing shadow.
              data   <= {din, shadow[LANES-2:0]};
              done   <= 1'b1;
              lane   <= '0;
              select <= '1;
            end else begin
              lane   <= lane + 3'd1;
              select <= lane_code(lane + 3'd1);
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        default: begin
          lane  <= '0;
          dwell <= '0;
          if (state_nxt == SCAN) select <= lane_code(3'd0);
          else                   select <= '1;
        end
      endcase
    end
  end

`ifdef SCAN_IDLE_CHECK_EN
  // All select lines high during GAP: the mux must read back a 1.
  always_ff @(posedge clk) begin
    if (reset)                        err <= 1'b0;
    else if (state == GAP && !din)    err <= 1'b1;
  end
`endif

endmodule
